// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles UART bytes into framed commands
// (header, CMD, LEN, payload, CHK). Good frames are published with a
// one-cycle frame_valid; aborted frames raise a one-cycle frame_err
// and a held err_code.
//
// Input handshake: rx_valid is a one-cycle strobe with no back-pressure.
// Every strobed byte is consumed in the cycle it arrives. Results
// (frame_valid / frame_err) appear in the cycle after the deciding strobe.
module uart_cmd_parser #(
  parameter int          SYSCLKHZ    = 125_000_000,
  parameter int          MAX_LEN     = 8,
  parameter int          TIMEOUT_CYC = SYSCLKHZ / 1000,
  parameter logic [7:0]  HEADER      = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           cmd,
  output logic [3:0]           len,
  output logic [8*MAX_LEN-1:0] payload,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic [4:0]           state_dbg
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_CMD  = 5'b00010;
  localparam logic [4:0] S_LEN  = 5'b00100;
  localparam logic [4:0] S_DATA = 5'b01000;
  localparam logic [4:0] S_CHK  = 5'b10000;

  logic [4:0]           state;
  logic [CW-1:0]        to_cnt;
  logic [3:0]           idx;
  logic [7:0]           chk;
  logic [7:0]           cmd_sh;
  logic [3:0]           len_sh;
  logic [8*MAX_LEN-1:0] pay_sh;
  logic                 timeout_hit;

  // A strobe in the terminal-count cycle wins over the timeout.
  assign timeout_hit = (state != S_IDLE) && !rx_valid && (to_cnt == TO_LAST);
  assign state_dbg   = state;

  // Inter-byte idle counter, only running while a frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == S_IDLE || rx_valid || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Frame FSM, shadow capture, checksum and output publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      chk         <= '0;
      cmd_sh      <= '0;
      len_sh      <= '0;
      pay_sh      <= '0;
      cmd         <= '0;
      len         <= '0;
      payload     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (timeout_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'b11;
        state     <= S_IDLE;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == HEADER) begin
              chk    <= '0;
              pay_sh <= '0;
              state  <= S_CMD;
            end
          end
          S_CMD: begin
            cmd_sh <= rx_data;
            chk    <= rx_data;
            state  <= S_LEN;
          end
          S_LEN: begin
            if (rx_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
              state     <= S_IDLE;
            end else begin
              chk    <= chk ^ rx_data;
              len_sh <= rx_data[3:0];
              idx    <= '0;
              state  <= (rx_data == 8'd0) ? S_CHK : S_DATA;
            end
          end
          S_DATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) pay_sh[8*i +: 8] <= rx_data;
            end
            chk <= chk ^ rx_data;
            if (idx == len_sh - 4'd1) begin
              state <= S_CHK;
            end else begin
              idx <= idx + 4'd1;
            end
          end
          S_CHK: begin
            if (rx_data == chk) begin
              cmd         <= cmd_sh;
              len         <= len_sh;
              payload     <= pay_sh;
              frame_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'b10;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frames against a
// queue-based frame model, plus literal checks on the directed cases.
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 8;
  localparam int TO_CYC  = 100;
  localparam int PW      = 8 * MAX_LEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    cmd;
  logic [3:0]    len;
  logic [PW-1:0] payload;
  logic          frame_valid;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [4:0]    state_dbg;

  uart_cmd_parser #(
    .SYSCLKHZ(100_000), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO_CYC), .HEADER(8'hAA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd(cmd), .len(len), .payload(payload), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_code(err_code), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The open frame is a queue of the bytes after the header; a frame
  // closes when LEN is illegal, when it holds CMD+LEN+payload+CHK, or
  // after TO_CYC edges without a byte.
  logic [7:0]    fq[$];
  bit            in_frame = 0;
  int            idle = 0;
  logic          m_fv, m_fe;
  logic [1:0]    m_ec;
  logic [7:0]    m_cmd;
  logic [3:0]    m_len;
  logic [PW-1:0] m_pay;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete(); in_frame = 0; idle = 0;
      m_fv = 0; m_fe = 0; m_ec = 0; m_cmd = 0; m_len = 0; m_pay = 0;
    end else begin
      m_fv = 0; m_fe = 0;
      if (rx_valid) begin
        idle = 0;
        if (!in_frame) begin
          if (rx_data == 8'hAA) begin in_frame = 1; fq.delete(); end
        end else begin
          fq.push_back(rx_data);
          if (fq.size() == 2 && fq[1] > 8'(MAX_LEN)) begin
            m_fe = 1; m_ec = 2'b01; in_frame = 0;
          end else if (fq.size() >= 2 && fq.size() == int'(fq[1]) + 3) begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < fq.size() - 1; i++) x ^= fq[i];
            if (x == fq[fq.size()-1]) begin
              m_fv = 1; m_cmd = fq[0]; m_len = fq[1][3:0]; m_pay = '0;
              for (int i = 0; i < int'(fq[1]); i++) m_pay[8*i +: 8] = fq[2+i];
            end else begin
              m_fe = 1; m_ec = 2'b10;
            end
            in_frame = 0;
          end
        end
      end else if (in_frame) begin
        idle++;
        if (idle == TO_CYC) begin m_fe = 1; m_ec = 2'b11; in_frame = 0; end
      end
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  bit run_cmp = 0;
  int cyc = 0, strobe_cyc = 0, err_cyc = 0, fv_cnt = 0, fe_cnt = 0;

  // Cycle index counts sampling edges; strobe_cyc is the edge that took a byte.
  always @(posedge clk) begin
    cyc++;
    if (rx_valid) strobe_cyc = cyc;
  end

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err) begin fe_cnt++; err_cyc = cyc; end
    if (run_cmp) begin
      check("frame_valid", PW'(frame_valid), PW'(m_fv));
      check("frame_err", PW'(frame_err), PW'(m_fe));
      check("err_code", PW'(err_code), PW'(m_ec));
      check("cmd", PW'(cmd), PW'(m_cmd));
      check("len", PW'(len), PW'(m_len));
      check("payload", payload, m_pay);
      if (frame_valid && frame_err) check("both_pulses", 1, 0);
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] tx_q[$];
  int         gap_q[$];

  // Called at a negedge; strobes one byte then holds rx_valid low for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) begin
      send_byte(tx_q.pop_front(), (gap_q.size() > 0) ? gap_q.pop_front() : 2);
    end
    gap_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2;
    check("rst_cmd", PW'(cmd), 0);
    check("rst_len", PW'(len), 0);
    check("rst_payload", payload, 0);
    check("rst_err_code", PW'(err_code), 0);
    check("rst_pulses", PW'({frame_valid, frame_err}), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_frame();
    int kind, n, to_pos;
    logic [7:0] x, b;
    kind = $urandom_range(0, 9);
    tx_q.push_back(8'hAA);
    b = 8'($urandom); tx_q.push_back(b); x = b;
    if (kind == 7) begin
      tx_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
    end else if (kind == 8) begin
      tx_q.delete();
      repeat ($urandom_range(1, 3)) tx_q.push_back(8'($urandom_range(0, 8'hA9)));
    end else begin
      n = $urandom_range(0, MAX_LEN);
      tx_q.push_back(8'(n)); x ^= 8'(n);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom); tx_q.push_back(b); x ^= b;
      end
      tx_q.push_back((kind == 6) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    end
    to_pos = (kind == 9) ? $urandom_range(0, tx_q.size() - 2) : -1;
    for (int i = 0; i < tx_q.size(); i++)
      gap_q.push_back((i == to_pos) ? $urandom_range(TO_CYC - 3, TO_CYC + 3) : $urandom_range(1, 4));
    send_q();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fv0, fe0;
    repeat (3) @(posedge clk);
    #2;
    check("init_cmd", PW'(cmd), 0);
    check("init_payload", payload, 0);
    check("init_err_code", PW'(err_code), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_cmp = 1;

    // good frame
    fv0 = fv_cnt;
    tx_q = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}; send_q();
    check("good_cmd", PW'(cmd), PW'(8'h01));
    check("good_len", PW'(len), 2);
    check("good_payload", payload, PW'(16'h2010));
    check("good_pulse_count", PW'(fv_cnt - fv0), 1);

    // zero-length frame
    tx_q = '{8'hAA, 8'h05, 8'h00, 8'h05}; send_q();
    check("zero_cmd", PW'(cmd), PW'(8'h05));
    check("zero_len", PW'(len), 0);
    check("zero_payload", payload, 0);

    // bad checksum keeps previous outputs
    fe0 = fe_cnt;
    tx_q = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34}; send_q();
    check("badchk_code", PW'(err_code), PW'(2'b10));
    check("badchk_cmd_kept", PW'(cmd), PW'(8'h05));
    check("badchk_err_count", PW'(fe_cnt - fe0), 1);
    tx_q = '{8'hAA, 8'h07, 8'h00, 8'h07}; send_q();
    check("after_badchk_cmd", PW'(cmd), PW'(8'h07));

    // LEN overflow: pulse in the cycle following the LEN sampling edge
    tx_q = '{8'hAA, 8'h01, 8'h09}; send_q();
    check("len_err_code", PW'(err_code), PW'(2'b01));
    check("len_err_latency", PW'(err_cyc - strobe_cyc), 0);
    tx_q = '{8'hAA, 8'h02, 8'h00, 8'h02}; send_q();
    check("after_len_cmd", PW'(cmd), PW'(8'h02));

    // timeout: 100 cycles after the last strobe
    tx_q = '{8'hAA, 8'h01}; gap_q = '{2, TO_CYC + 10}; send_q();
    check("timeout_code", PW'(err_code), PW'(2'b11));
    check("timeout_latency", PW'(err_cyc - strobe_cyc), TO_CYC);

    // byte in the terminal-count cycle is accepted
    fe0 = fe_cnt; fv0 = fv_cnt;
    tx_q = '{8'hAA, 8'h01, 8'h00, 8'h01}; gap_q = '{2, TO_CYC - 1, 2, 2}; send_q();
    check("late_byte_no_err", PW'(fe_cnt - fe0), 0);
    check("late_byte_frame", PW'(fv_cnt - fv0), 1);
    check("late_byte_cmd", PW'(cmd), PW'(8'h01));

    // noise before a frame
    fe0 = fe_cnt; fv0 = fv_cnt;
    tx_q = '{8'h55, 8'h00, 8'hFF, 8'hAA, 8'h03, 8'h01, 8'h44, 8'h46}; send_q();
    check("noise_frames", PW'(fv_cnt - fv0), 1);
    check("noise_errs", PW'(fe_cnt - fe0), 0);
    check("noise_payload", payload, PW'(8'h44));

    // reset mid-frame
    fe0 = fe_cnt; fv0 = fv_cnt;
    tx_q = '{8'hAA, 8'h03}; send_q();
    pulse_reset();
    check("reset_no_pulse", PW'((fe_cnt - fe0) + (fv_cnt - fv0)), 0);
    tx_q = '{8'hAA, 8'h03, 8'h01, 8'h44, 8'h46}; send_q();
    check("post_reset_cmd", PW'(cmd), PW'(8'h03));
    check("post_reset_payload", payload, PW'(8'h44));

    // randomized traffic, checked cycle by cycle against the model
    repeat (250) rand_frame();
    repeat (TO_CYC + 20) @(negedge clk);

    run_cmp = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream: 8-bit data plus a one-cycle valid strobe.
- Assembles bytes into command frames: header 0xAA, CMD, LEN, LEN payload bytes, CHK.
- Validates each frame and presents the command and payload to the controller logic with a one-cycle done pulse.
- Flags malformed and stalled frames with a one-cycle error pulse and an error code.

Parameters:
- SYSCLKHZ, 125_000_000, system clock frequency in Hz.
- MAX_LEN, 8, maximum payload bytes per frame (1..15).
- TIMEOUT_CYC, SYSCLKHZ/1000, idle cycles allowed between bytes inside a frame (1 ms).
- HEADER, 8'hAA, frame start byte.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
- cmd  output  8  command byte of the last good frame.
- len  output  4  payload length of the last good frame.
- payload  output  8*MAX_LEN  payload of the last good frame; byte i occupies [8*i+7:8*i].
- frame_valid  output  1  one-cycle pulse when a good frame completes.
- frame_err  output  1  one-cycle pulse when a frame is aborted.
- err_code  output  2  abort cause, held until the next abort: 01 = bad LEN, 10 = checksum mismatch, 11 = timeout.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0; the FSM goes to IDLE.
  - Byte index, timeout counter, running checksum and shadow payload go to 0.
  - Reset mid-frame discards the partial frame, with no err pulse.
- One-hot FSM: IDLE, CMD, LEN, DATA, CHK. State advances only on cycles where rx_valid=1, except for timeout.
- IDLE:
  - rx_valid with rx_data==HEADER -> CMD; clear the running checksum and the shadow payload.
  - Any other byte is dropped silently, with no error.
- CMD: on rx_valid, store the byte to shadow cmd, set checksum = byte, go to LEN.
- LEN:
  - On rx_valid, if byte > MAX_LEN: frame_err=1, err_code=01, go to IDLE.
  - If byte == 0: go to CHK.
  - Otherwise: store the byte, index=0, go to DATA.
  - In every non-error case, checksum ^= byte.
- DATA:
  - On rx_valid, write the byte to shadow payload[index] and checksum ^= byte.
  - If index == len-1, go to CHK; otherwise index++.
- CHK: on rx_valid:
  - If byte == checksum: copy shadow cmd, len and payload to the outputs, frame_valid=1. Unused payload bytes read 0.
  - Otherwise: frame_err=1, err_code=10; outputs keep their previous values.
  - Either way, go to IDLE.
- Checksum is the 8-bit XOR of CMD, LEN and all payload bytes. The header is excluded.
- Latency: frame_valid or frame_err asserts in the cycle after the rx_valid of the deciding byte. Each pulse is exactly one cycle wide.
- Timeout:
  - The counter runs only outside IDLE and clears on every accepted rx_valid.
  - When it reaches TIMEOUT_CYC-1: frame_err=1, err_code=11, go to IDLE.
  - If rx_valid and the timeout terminal count occur in the same cycle, the byte wins: it is accepted, the counter clears, and no error is raised.
  - Counter width is $clog2(TIMEOUT_CYC).
- A HEADER byte arriving mid-frame is treated as ordinary data. There is no resync until IDLE.
- frame_valid and frame_err are never asserted in the same cycle.
- A new frame may begin on the rx_valid immediately after the CHK byte, with no dead cycle required.
- rx_valid pulses are assumed at least 2 cycles apart; the UART guarantees this.

Test Plan:
- Good frame: bytes AA 01 02 10 20 with CHK = 01^02^10^20 = 0x33 -> one frame_valid pulse; cmd=0x01, len=2, payload[15:0]=0x2010, upper bytes 0.
- Zero-length frame: AA 05 00 05 -> frame_valid; cmd=0x05, len=0, payload=0.
- Bad checksum: AA 01 02 10 20 34 -> frame_err, err_code=10; cmd and payload keep the values from the prior good frame. Then AA 07 00 07 -> frame_valid, cmd=0x07.
- LEN overflow with MAX_LEN=8: AA 01 09 -> frame_err, err_code=01 one cycle after the LEN strobe. Then the following AA 02 00 02 parses OK.
- Timeout with TIMEOUT_CYC=100 for the sim: AA 01 then silence -> frame_err, err_code=11 exactly 100 cycles after the last strobe. Also check a byte strobed at cycle 99 is accepted with no error.
- Noise and reset:
  - Bytes 55 00 FF before AA 03 01 44 46 -> only that frame is reported, with payload byte0=0x44.
  - rst_n pulsed low after AA 03 -> all outputs 0, no pulse, and the next full frame parses normally.
